piezo_sound_sequencer: RTL

Drives the shared piezo. It plays short melodies when the main FSM state changes: start, phase advance, defused and explosion. It also plays a click beep on keypad presses. It sits downstream of the game top-level: it consumes current_state, key_pulse and the event-1 warning tone (ev1_piezo) and produces the final piezo_out pin. This replaces the direct ev1_piezo assignment.

---
 rtl/piezo_sound_sequencer_if.sv | 21 ++
 rtl/piezo_sound_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/piezo_sound_sequencer_if.sv
// rtl/piezo_sound_sequencer_if.sv - game-side signal bundle for the piezo sound sequencer
interface piezo_sound_sequencer_if;
    logic [2:0] current_state;
    logic       key_pulse;
    logic       warn_en;
    logic       warn_in;
    logic       mute;
    logic       piezo_out;
    logic       busy;
    logic [2:0] melody_id;

    modport master (
        output current_state, key_pulse, warn_en, warn_in, mute,
        input  piezo_out, busy, melody_id
    );

    modport slave (
        input  current_state, key_pulse, warn_en, warn_in, mute,
        output piezo_out, busy, melody_id
    );
endinterface

// File: rtl/piezo_sound_sequencer.sv
// rtl/piezo_sound_sequencer.sv - melody/click sequencer driving the shared piezo pin
module piezo_sound_sequencer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int UNIT_MS  = 100,
    parameter int GAP_MS   = 10,
    parameter int CLICK_MS = 20
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    piezo_sound_sequencer_if.slave   bus
);

    localparam int TICK  = CLK_HZ / 1000;
    localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);

    localparam logic [2:0] ID_NONE  = 3'd0;
    localparam logic [2:0] ID_CLICK = 3'd1;
    localparam logic [2:0] ID_START = 3'd2;
    localparam logic [2:0] ID_PHASE = 3'd3;
    localparam logic [2:0] ID_CLEAR = 3'd4;
    localparam logic [2:0] ID_FAIL  = 3'd5;

    localparam logic [2:0] N_REST = 3'd0;
    localparam logic [2:0] N_A4   = 3'd1;
    localparam logic [2:0] N_D4   = 3'd2;
    localparam logic [2:0] N_F4   = 3'd3;
    localparam logic [2:0] N_C5   = 3'd4;
    localparam logic [2:0] N_E5   = 3'd5;
    localparam logic [2:0] N_G5   = 3'd6;
    localparam logic [2:0] N_C6   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    function automatic logic [16:0] half_period(input logic [2:0] note);
        case (note)
            N_A4:    half_period = 17'(CLK_HZ / (2 * 440));
            N_D4:    half_period = 17'(CLK_HZ / (2 * 294));
            N_F4:    half_period = 17'(CLK_HZ / (2 * 349));
            N_C5:    half_period = 17'(CLK_HZ / (2 * 523));
            N_E5:    half_period = 17'(CLK_HZ / (2 * 659));
            N_G5:    half_period = 17'(CLK_HZ / (2 * 784));
            N_C6:    half_period = 17'(CLK_HZ / (2 * 1047));
            default: half_period = 17'd0;
        endcase
    endfunction

    // Entry layout: {note[2:0], length in units[3:0], last-note flag}
    function automatic logic [7:0] melody_rom(input logic [2:0] id, input logic [1:0] idx);
        case ({id, idx})
            {ID_CLICK, 2'd0}: melody_rom = {N_C6, 4'd0, 1'b1};
            {ID_START, 2'd0}: melody_rom = {N_C5, 4'd1, 1'b0};
            {ID_START, 2'd1}: melody_rom = {N_E5, 4'd1, 1'b0};
            {ID_START, 2'd2}: melody_rom = {N_G5, 4'd2, 1'b1};
            {ID_PHASE, 2'd0}: melody_rom = {N_G5, 4'd1, 1'b0};
            {ID_PHASE, 2'd1}: melody_rom = {N_C6, 4'd1, 1'b1};
            {ID_CLEAR, 2'd0}: melody_rom = {N_C5, 4'd1, 1'b0};
            {ID_CLEAR, 2'd1}: melody_rom = {N_E5, 4'd1, 1'b0};
            {ID_CLEAR, 2'd2}: melody_rom = {N_G5, 4'd1, 1'b0};
            {ID_CLEAR, 2'd3}: melody_rom = {N_C6, 4'd4, 1'b1};
            {ID_FAIL,  2'd0}: melody_rom = {N_A4, 4'd2, 1'b0};
            {ID_FAIL,  2'd1}: melody_rom = {N_F4, 4'd2, 1'b0};
            {ID_FAIL,  2'd2}: melody_rom = {N_D4, 4'd6, 1'b1};
            default:          melody_rom = {N_REST, 4'd1, 1'b1};
        endcase
    endfunction

    state_t           state;
    logic [2:0]       prev_state;
    logic [1:0]       note_idx;
    logic [16:0]      hp;
    logic [16:0]      tone_cnt;
    logic             phase;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      ms_cnt;
    logic [15:0]      dur_ms;
    logic [15:0]      gap_start;
    logic             last_note;

    logic             req_mel;
    logic             req_abort;
    logic [2:0]       req_id;
    logic [2:0]       ent_note;
    logic [3:0]       ent_units;
    logic             ent_last;
    logic [15:0]      ent_dur;
    logic [15:0]      ent_gap;
    logic             tone_on;
    logic             note_end;

    always_comb begin
        req_mel   = 1'b0;
        req_abort = 1'b0;
        req_id    = ID_NONE;
        if (bus.current_state != prev_state) begin
            case (bus.current_state)
                3'd0: req_abort = 1'b1;
                3'd1: begin
                    req_mel = 1'b1;
                    req_id  = (prev_state == 3'd0) ? ID_START : ID_PHASE;
                end
                3'd2, 3'd3, 3'd4: begin
                    req_mel = 1'b1;
                    req_id  = ID_PHASE;
                end
                3'd5: begin
                    req_mel = 1'b1;
                    req_id  = ID_CLEAR;
                end
                3'd6: begin
                    req_mel = 1'b1;
                    req_id  = ID_FAIL;
                end
                default: ;
            endcase
        end
    end

    // Clicks have their own length in ms and no articulation gap.
    always_comb begin
        {ent_note, ent_units, ent_last} = melody_rom(bus.melody_id, note_idx);
        if (bus.melody_id == ID_CLICK) begin
            ent_dur = 16'(CLICK_MS);
            ent_gap = ent_dur;
        end else begin
            ent_dur = 16'(ent_units) * 16'(UNIT_MS);
            ent_gap = ent_dur - 16'(GAP_MS);
        end
    end

    assign tone_on  = phase && (ms_cnt < gap_start) && (hp != 17'd0);
    assign note_end = (pre_cnt == PRE_LAST) && (ms_cnt == dur_ms - 16'd1);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state         <= S_IDLE;
            prev_state    <= 3'd0;
            note_idx      <= 2'd0;
            hp            <= 17'd0;
            tone_cnt      <= 17'd0;
            phase         <= 1'b0;
            pre_cnt       <= '0;
            ms_cnt        <= 16'd0;
            dur_ms        <= 16'd0;
            gap_start     <= 16'd0;
            last_note     <= 1'b0;
            bus.piezo_out <= 1'b0;
            bus.busy      <= 1'b0;
            bus.melody_id <= ID_NONE;
        end else begin
            prev_state <= bus.current_state;

            // Warning tone overrides mute; the sequencer keeps its timing underneath.
            if (bus.warn_en)
                bus.piezo_out <= bus.warn_in;
            else
                bus.piezo_out <= !bus.mute && (state == S_PLAY) && tone_on;

            if (req_mel) begin
                state         <= S_LOAD;
                bus.busy      <= 1'b1;
                bus.melody_id <= req_id;
                note_idx      <= 2'd0;
            end else if (req_abort) begin
                state         <= S_IDLE;
                bus.busy      <= 1'b0;
                bus.melody_id <= ID_NONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.key_pulse) begin
                            state         <= S_LOAD;
                            bus.busy      <= 1'b1;
                            bus.melody_id <= ID_CLICK;
                            note_idx      <= 2'd0;
                        end
                    end
                    S_LOAD: begin
                        hp        <= half_period(ent_note);
                        dur_ms    <= ent_dur;
                        gap_start <= ent_gap;
                        last_note <= ent_last;
                        tone_cnt  <= 17'd0;
                        phase     <= 1'b0;
                        pre_cnt   <= '0;
                        ms_cnt    <= 16'd0;
                        state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (tone_cnt == hp - 17'd1) begin
                            tone_cnt <= 17'd0;
                            phase    <= ~phase;
                        end else begin
                            tone_cnt <= tone_cnt + 17'd1;
                        end
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= '0;
                            ms_cnt  <= ms_cnt + 16'd1;
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                        if (note_end) begin
                            if (last_note) begin
                                state         <= S_IDLE;
                                bus.busy      <= 1'b0;
                                bus.melody_id <= ID_NONE;
                            end else begin
                                state    <= S_LOAD;
                                note_idx <= note_idx + 2'd1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
